midi_learn_ctrl: RTL
====================

# midi_learn_ctrl

Parametrised MIDI foot-controller core: maps BTN_CNT debounced button pulses to MIDI messages on a 31250-baud TX line, and learns per-button messages from a MIDI RX stream. It replaces the two-button controller. All logic runs on `clk`, with a baud clock-enable instead of a derived clock. It sits between the per-button debounce instances and the MIDI DIN drivers.

## Interface
- BTN_CNT, 4: number of buttons/message slots (1..16)
- BAUD_DIV, 3200: clk cycles per MIDI bit (100 MHz / 31250)
- LEARN_WIN, 30: learn window length, in bit periods, after a received message completes
- DEF_CC, 46: slot i default message is CC (DEF_CC+i), value 127
- CHANNEL, 0: MIDI channel (0..15) of default messages
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- btn_press  in  BTN_CNT  one-cycle press pulses from debounce
- midi_rx  in  1  MIDI IN, asynchronous, idle high
- midi_tx  out  1  MIDI OUT, idle high
- learn_led  out  1  high while learn window open
- busy  out  1  high while a TX frame is in progress or presses are pending

## Operation
- RX: 2-flop synchroniser. A falling edge starts a frame. Each bit is sampled at BAUD_DIV/2 into the bit. 8 data bits are received LSB first. A stop bit of 0 is a framing error and the byte is dropped.
- RX parser:
  - 0x80-0xEF: latch running status. Expected data length is 1 for 0xC_/0xD_ and 2 otherwise.
  - 0xF0-0xF7: clear running status.
  - 0xF8-0xFF: ignored, with no effect on parser state.
  - Data byte with no running status: ignored.
  - Data bytes fill d1, then d2. The message completes when the expected count is reached.
  - Running status: further data bytes start a new message under the same status.
- Completed message: copy to capture register, open learn window (learn_led=1), reload window counter to LEARN_WIN. The counter decrements on each baud tick and the window closes at 0. A new completed message reloads the counter and replaces the capture.
- Button press while window open: write the capture into slot i, mark slot i valid, close the window. No TX.
  - Simultaneous presses: the lowest index learns.
  - Other presses in the same cycle are ignored.
- Button press while window closed: set pending[i]. A press on an already-pending bit is absorbed.
- TX arbiter: when idle and pending is non-zero, take the lowest set index and clear its bit.
  - Load slot contents if valid, else the default CC.
  - Frame: start 0, 8 data bits LSB first, stop 1, per byte. 2 or 3 bytes back to back.
- Reset: slots invalid, pending cleared, window closed, parser status cleared. midi_tx=1, learn_led=0, busy=0.

## Timing
- Press at cycle t → pending set at t+1. If TX is idle, midi_tx falls at t+2.
- Each bit is held exactly BAUD_DIV cycles. The baud counter restarts at frame start.
- The next queued message starts the cycle after the last stop bit completes.
- A 3-byte message is 30 bit periods long; a 2-byte message is 20.
- Learn window opens the cycle after the stop-bit sample of the final data byte.
- busy rises with pending, and falls the cycle after the last stop bit if nothing is pending.

## Configuration
- MIDI_TX_RUNNING_STATUS_EN defined: the status byte is omitted when it equals the last transmitted status.
  - The last-status register clears on reset.
  - Frames become 1 or 2 bytes.
- MIDI_TX_RUNNING_STATUS_EN undefined: status is always sent.

## Structure
- Package `midi_pkg` holds:
  - `midi_msg_t` {status, d1, d2, len[1:0]}
  - status constants CC=0xB0, PC=0xC0
  - function `midi_data_len(status)`
- Sub-module `midi_uart_rx` (BAUD_DIV): sync, sampling, framing. Outputs byte plus one-cycle valid.
- TX serialiser, parser, slot RAM, arbiter and learn timer live in `midi_learn_ctrl`.

## Test plan
Sim uses BAUD_DIV=16, BTN_CNT=4.
- Reset, press btn 2 → midi_tx sends B0 30 7F (CC 48), 30 bits, busy falls after.
- RX C0 42, then within the window press btn 1 → learn_led 1→0, no TX. Next btn 1 press sends C0 42 (20 bits).
- RX B0 07 64 then 07 10 (running status), press btn 0 → sends B0 07 10.
- Presses on btn 3 and 1 in the same cycle, then btn 3 again during TX → order btn1, btn3, with no third frame.
- RX byte with stop bit 0, and F8 between data bytes → the bad byte is dropped and F8 is ignored. The message still completes.
- MIDI_TX_RUNNING_STATUS_EN: two presses on unlearned slots 0 and 1 → second frame is 2F 7F only.

Source files
------------

// File: rtl/midi_pkg.sv
// -----------------------------------------------------------------------------
// midi_pkg
//   Shared types and helpers for the MIDI learn controller.
//   - midi_msg_t    : one channel message {status, d1, d2, len}
//                     len is the total byte count on the wire (2 or 3).
//   - CC, PC        : status nibbles for Control Change / Program Change.
//   - midi_data_len : number of data bytes that follow a channel status.
// -----------------------------------------------------------------------------
package midi_pkg;

  localparam logic [7:0] CC = 8'hB0;
  localparam logic [7:0] PC = 8'hC0;

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [1:0] len;
  } midi_msg_t;

  // Program Change (0xC_) and Channel Pressure (0xD_) carry a single data
  // byte; every other channel message carries two.
  function automatic logic [1:0] midi_data_len(input logic [7:0] status);
    if (status[7:4] == PC[7:4] || status[7:4] == 4'hD) begin
      return 2'd1;
    end
    return 2'd2;
  endfunction

endpackage

// File: rtl/midi_learn_ctrl_if.sv
// -----------------------------------------------------------------------------
// midi_learn_ctrl_if
//   Bundles the controller's functional signals.
//   btn_press : one-cycle press pulses from the debounce instances
//   midi_rx   : MIDI IN line, asynchronous, idle high
//   midi_tx   : MIDI OUT line, idle high
//   learn_led : high while the learn window is open
//   busy      : high while a TX frame runs or presses are pending
//   rx_state  : receiver FSM state (debug)
//   tx_state  : transmitter FSM state (debug)
//   Modports: master = button/line side, slave = the controller.
// -----------------------------------------------------------------------------
interface midi_learn_ctrl_if #(
  parameter int BTN_CNT = 4
);
  logic [BTN_CNT-1:0] btn_press;
  logic               midi_rx;
  logic               midi_tx;
  logic               learn_led;
  logic               busy;
  logic [1:0]         rx_state;
  logic [0:0]         tx_state;

  modport master (
    output btn_press, midi_rx,
    input  midi_tx, learn_led, busy, rx_state, tx_state
  );

  modport slave (
    input  btn_press, midi_rx,
    output midi_tx, learn_led, busy, rx_state, tx_state
  );
endinterface

// File: rtl/midi_uart_rx.sv
// -----------------------------------------------------------------------------
// midi_uart_rx
//   MIDI byte receiver: 2-flop synchroniser, falling-edge start detection,
//   mid-bit sampling, 8 data bits LSB first, stop-bit check.
//   Ports:
//     clk, rst    : clock, asynchronous active-low reset
//     rx          : raw MIDI IN line (idle high)
//     byte_data   : last received byte
//     byte_valid  : one-cycle strobe, byte_data is a good byte
//     state_dbg   : receiver FSM state
//   A byte whose stop bit reads 0 is a framing error and never strobes.
// -----------------------------------------------------------------------------
module midi_uart_rx #(
  parameter int BAUD_DIV = 3200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic [1:0] state_dbg
);

  localparam int DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [DIV_W-1:0] HALF_END = DIV_W'(BAUD_DIV / 2 - 1);
  localparam logic [DIV_W-1:0] FULL_END = DIV_W'(BAUD_DIV - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic [1:0]       sync_q;
  logic             rx_s;
  logic             rx_prev;
  logic [1:0]       state;
  logic [DIV_W-1:0] div;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= 2'b11;
      rx_prev <= 1'b1;
      state   <= RX_IDLE;
      div     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      rx_prev <= rx_s;
      case (state)
        RX_IDLE: begin
          // Only a high-to-low transition starts a frame, so a line held
          // low after a framing error does not retrigger.
          if (rx_prev && !rx_s) begin
            state <= RX_START;
            div   <= '0;
          end
        end
        RX_START: begin
          if (div == HALF_END) begin
            div <= '0;
            if (rx_s) begin
              state <= RX_IDLE;          // glitch, not a real start bit
            end else begin
              state   <= RX_DATA;
              bit_cnt <= '0;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        RX_DATA: begin
          if (div == FULL_END) begin
            div     <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              state <= RX_STOP;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        default: begin
          if (div == FULL_END) begin
            div   <= '0;
            state <= RX_IDLE;
          end else begin
            div <= div + 1'b1;
          end
        end
      endcase
    end
  end

  assign byte_data  = shift;
  assign byte_valid = (state == RX_STOP) && (div == FULL_END) && rx_s;
  assign state_dbg  = state;

endmodule

// File: rtl/midi_learn_ctrl.sv
// -----------------------------------------------------------------------------
// midi_learn_ctrl
//   MIDI foot-controller core. Each button slot sends a stored message on
//   MIDI OUT; a message received on MIDI IN opens a learn window, and a
//   press inside that window stores the message into the pressed slot.
//   Ports:
//     clk  : system clock
//     rst  : asynchronous active-low reset
//     bus  : midi_learn_ctrl_if.slave (btn_press, midi_rx in;
//            midi_tx, learn_led, busy, rx_state, tx_state out)
//   Parameters: BTN_CNT slots, BAUD_DIV clocks per bit, LEARN_WIN window
//   length in bit periods, DEF_CC / CHANNEL for unlearned slots
//   (slot i sends CC DEF_CC+i, value 127).
//   Build option: MIDI_TX_RUNNING_STATUS_EN omits the status byte when it
//   equals the status of the previously transmitted message.
//
//   Handshake: the receiver's byte_valid and the button pulses are
//   single-cycle strobes with no ready/back-pressure; the controller always
//   accepts them in the cycle they are high.
// -----------------------------------------------------------------------------
module midi_learn_ctrl
  import midi_pkg::*;
#(
  parameter int BTN_CNT   = 4,
  parameter int BAUD_DIV  = 3200,
  parameter int LEARN_WIN = 30,
  parameter int DEF_CC    = 46,
  parameter int CHANNEL   = 0
) (
  input  logic             clk,
  input  logic             rst,
  midi_learn_ctrl_if.slave bus
);

  localparam int IDX_W = (BTN_CNT > 1) ? $clog2(BTN_CNT) : 1;
  localparam int DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int WIN_W = $clog2(LEARN_WIN + 1);
  localparam logic [DIV_W-1:0] DIV_END    = DIV_W'(BAUD_DIV - 1);
  localparam logic [7:0]       DEF_STATUS = CC | {4'h0, 4'(CHANNEL)};
  localparam logic [7:0]       DEF_BASE   = 8'(DEF_CC);

  localparam logic [0:0] TX_IDLE = 1'b0;
  localparam logic [0:0] TX_SEND = 1'b1;

  // ---------------------------------------------------------------- receiver
  logic [7:0] rx_byte;
  logic       rx_valid;

  midi_uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (bus.midi_rx),
    .byte_data (rx_byte),
    .byte_valid(rx_valid),
    .state_dbg (bus.rx_state)
  );

  // ------------------------------------------------------------------ parser
  logic [7:0] run_status;
  logic       has_status;
  logic [1:0] exp_len;
  logic       got_d1;
  logic [7:0] d1_q;
  logic       msg_done;
  midi_msg_t  msg_new;

  // A data byte completes a message when it is the only data byte the
  // status needs, or when it is the second byte of a two-byte message.
  always_comb begin
    msg_done       = 1'b0;
    msg_new.status = run_status;
    msg_new.d1     = d1_q;
    msg_new.d2     = 8'h00;
    msg_new.len    = 2'd2;
    if (rx_valid && !rx_byte[7] && has_status) begin
      if (!got_d1 && exp_len == 2'd1) begin
        msg_done   = 1'b1;
        msg_new.d1 = rx_byte;
      end else if (got_d1) begin
        msg_done    = 1'b1;
        msg_new.d2  = rx_byte;
        msg_new.len = 2'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_status <= '0;
      has_status <= 1'b0;
      exp_len    <= 2'd2;
      got_d1     <= 1'b0;
      d1_q       <= '0;
    end else if (rx_valid) begin
      if (rx_byte[7:4] == 4'hF) begin
        // 0xF8-0xFF are real-time bytes and leave the parser untouched.
        if (!rx_byte[3]) begin
          has_status <= 1'b0;
          got_d1     <= 1'b0;
        end
      end else if (rx_byte[7]) begin
        run_status <= rx_byte;
        has_status <= 1'b1;
        exp_len    <= midi_data_len(rx_byte);
        got_d1     <= 1'b0;
      end else if (has_status) begin
        if (msg_done) begin
          got_d1 <= 1'b0;              // running status: next data byte restarts
        end else begin
          got_d1 <= 1'b1;
          d1_q   <= rx_byte;
        end
      end
    end
  end

  // ----------------------------------------------------------- learn window
  logic             learn_open;
  logic [WIN_W-1:0] win_cnt;
  logic [DIV_W-1:0] win_div;
  midi_msg_t        capture;
  logic [IDX_W-1:0] learn_idx;
  logic             learn_now;

  always_comb begin
    learn_idx = '0;
    for (int i = BTN_CNT - 1; i >= 0; i--) begin
      if (bus.btn_press[i]) begin
        learn_idx = IDX_W'(i);
      end
    end
  end

  assign learn_now = learn_open && (|bus.btn_press);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      learn_open <= 1'b0;
      win_cnt    <= '0;
      win_div    <= '0;
      capture    <= '0;
    end else begin
      if (learn_now) begin
        learn_open <= 1'b0;
      end else if (learn_open) begin
        if (win_div == DIV_END) begin
          win_div <= '0;
          win_cnt <= win_cnt - 1'b1;
          if (win_cnt == WIN_W'(1)) begin
            learn_open <= 1'b0;
          end
        end else begin
          win_div <= win_div + 1'b1;
        end
      end
      // A fresh message always wins: it reopens the window even in the
      // cycle a press closes it.
      if (msg_done) begin
        capture    <= msg_new;
        learn_open <= 1'b1;
        win_cnt    <= WIN_W'(LEARN_WIN);
        win_div    <= '0;
      end
    end
  end

  // -------------------------------------------------------------- slot RAM
  midi_msg_t          slot_msg [BTN_CNT];
  logic [BTN_CNT-1:0] slot_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BTN_CNT; i++) begin
        slot_msg[i] <= '0;
      end
      slot_valid <= '0;
    end else if (learn_now) begin
      slot_msg[learn_idx]   <= capture;
      slot_valid[learn_idx] <= 1'b1;
    end
  end

  // ------------------------------------------------------ pending / arbiter
  logic [BTN_CNT-1:0] pending;
  logic [IDX_W-1:0]   grant_idx;
  logic               tx_start;
  logic               tx_last_bit;
  logic [0:0]         tx_state;

  always_comb begin
    grant_idx = '0;
    for (int i = BTN_CNT - 1; i >= 0; i--) begin
      if (pending[i]) begin
        grant_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~(tx_start ? (BTN_CNT'(1) << grant_idx) : '0))
               | (learn_open ? '0 : bus.btn_press);
    end
  end

  // ------------------------------------------------------------ frame build
  midi_msg_t        sel_msg;
  logic [2:0][7:0]  frame_bytes;
  logic [1:0]       frame_len;

`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic [7:0] last_status;
`endif

  always_comb begin
    if (slot_valid[grant_idx]) begin
      sel_msg = slot_msg[grant_idx];
    end else begin
      sel_msg.status = DEF_STATUS;
      sel_msg.d1     = DEF_BASE + 8'(grant_idx);
      sel_msg.d2     = 8'h7F;
      sel_msg.len    = 2'd3;
    end
    frame_bytes[0] = sel_msg.status;
    frame_bytes[1] = sel_msg.d1;
    frame_bytes[2] = sel_msg.d2;
    frame_len      = sel_msg.len;
`ifdef MIDI_TX_RUNNING_STATUS_EN
    if (sel_msg.status == last_status) begin
      frame_bytes[0] = sel_msg.d1;
      frame_bytes[1] = sel_msg.d2;
      frame_bytes[2] = 8'h00;
      frame_len      = sel_msg.len - 2'd1;
    end
`endif
  end

  // ------------------------------------------------------------ serialiser
  logic [2:0][7:0]  tx_bytes;
  logic [1:0]       tx_nbytes;
  logic [1:0]       tx_byte_idx;
  logic [3:0]       tx_bit;          // 0 = start, 1..8 = data, 9 = stop
  logic [DIV_W-1:0] tx_div;
  logic             tx_out;

  assign tx_last_bit = (tx_state == TX_SEND) && (tx_div == DIV_END)
                     && (tx_bit == 4'd9) && (tx_byte_idx == tx_nbytes - 2'd1);
  // Back-to-back: the next queued message loads on the stop bit's last cycle.
  assign tx_start = (|pending) && ((tx_state == TX_IDLE) || tx_last_bit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state    <= TX_IDLE;
      tx_bytes    <= '0;
      tx_nbytes   <= '0;
      tx_byte_idx <= '0;
      tx_bit      <= '0;
      tx_div      <= '0;
      tx_out      <= 1'b1;
    end else if (tx_start) begin
      tx_state    <= TX_SEND;
      tx_bytes    <= frame_bytes;
      tx_nbytes   <= frame_len;
      tx_byte_idx <= '0;
      tx_bit      <= '0;
      tx_div      <= '0;
      tx_out      <= 1'b0;
    end else if (tx_state == TX_SEND) begin
      if (tx_div == DIV_END) begin
        tx_div <= '0;
        if (tx_bit == 4'd9) begin
          if (tx_byte_idx == tx_nbytes - 2'd1) begin
            tx_state <= TX_IDLE;
            tx_out   <= 1'b1;
          end else begin
            tx_byte_idx <= tx_byte_idx + 1'b1;
            tx_bit      <= '0;
            tx_out      <= 1'b0;
          end
        end else begin
          tx_bit <= tx_bit + 1'b1;
          tx_out <= (tx_bit == 4'd8) ? 1'b1 : tx_bytes[tx_byte_idx][tx_bit[2:0]];
        end
      end else begin
        tx_div <= tx_div + 1'b1;
      end
    end
  end

`ifdef MIDI_TX_RUNNING_STATUS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_status <= '0;
    end else if (tx_start) begin
      last_status <= sel_msg.status;
    end
  end
`endif

  // ---------------------------------------------------------------- outputs
  assign bus.midi_tx   = tx_out;
  assign bus.learn_led = learn_open;
  assign bus.busy      = (|pending) || (tx_state == TX_SEND);
  assign bus.tx_state  = tx_state;

endmodule
